// File: rtl/stopwatch_ctrl_if.sv
// Timer/display-side signal bundle of the stopwatch control front-end.
// The master modport is the control block; the slave modport is the timer/display logic.
interface stopwatch_ctrl_if;
    logic [23:0] time_in;
    logic        timer_start;
    logic        timer_clr_n;
    logic [23:0] disp_digits;
    logic        lap_valid;
    logic [1:0]  state;

    modport master (
        input  time_in,
        output timer_start,
        output timer_clr_n,
        output disp_digits,
        output lap_valid,
        output state
    );

    modport slave (
        output time_in,
        input  timer_start,
        input  timer_clr_n,
        input  disp_digits,
        input  lap_valid,
        input  state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: debounces the run and lap keys, runs the mode FSM,
// drives the timer enable/clear and selects live or lap-frozen digits for display.
module stopwatch_ctrl #(
    parameter int DB_CYCLES  = 1000000,
    parameter int CLR_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_run,
    input  logic             key_lap,
    stopwatch_ctrl_if.master bus
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_MAX = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_e;

    // Key index 0 is run, index 1 is lap; all key levels are active-low.
    logic [1:0]       keys_raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       level_q, level_d;
    logic [1:0]       armed_q, armed_d;
    logic [1:0]       press_q, press_d;
    logic [1:0]       flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    assign keys_raw = {key_lap, key_run};

    // A key becomes armed only once it has been seen released after reset, so a key
    // held through reset cannot fire until it is released and pressed again.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        flush_d = {flush_q[0], 1'b1};
        level_d = level_q;
        armed_d = armed_q;
        press_d = '0;
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != level_q[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    level_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
            armed_d[k] = armed_q[k] | (flush_q[1] & level_q[k] & sync2_q[k]);
            press_d[k] = armed_q[k] & level_q[k] & ~sync2_q[k] & (cnt_q[k] == CNT_MAX);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the counter array is
    // small and its reset value is part of the contract, so it is reset element by element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            level_q <= 2'b11;
            armed_q <= 2'b00;
            press_q <= 2'b00;
            flush_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
            flush_q <= flush_d;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    state_e           state_q, state_d;
    logic [23:0]      lap_q, lap_d;
    logic [23:0]      disp_q, disp_d;
    logic             start_q, start_d;
    logic             lap_valid_q, lap_valid_d;
    logic             clr_n_q, clr_n_d;
    logic [CLR_W-1:0] clr_rem_q, clr_rem_d;
    logic             run_ev, lap_ev;

    assign run_ev = press_q[0];
    assign lap_ev = press_q[1];

    always_comb begin
        state_d   = state_q;
        lap_d     = lap_q;
        clr_n_d   = clr_n_q;
        clr_rem_d = clr_rem_q;

        // The clear pulse runs to completion independently of further events.
        if (!clr_n_q) begin
            if (clr_rem_q == '0) begin
                clr_n_d = 1'b1;
            end else begin
                clr_rem_d = clr_rem_q - 1'b1;
            end
        end

        // run_ev is tested first everywhere, so a simultaneous lap press is dropped.
        unique case (state_q)
            IDLE: begin
                if (run_ev) state_d = RUN;
            end
            RUN: begin
                if (run_ev) begin
                    state_d = PAUSE;
                end else if (lap_ev) begin
                    state_d = LAP;
                    lap_d   = bus.time_in;
                end
            end
            LAP: begin
                if (run_ev) begin
                    state_d = PAUSE;
                end else if (lap_ev) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (run_ev) begin
                    state_d = RUN;
                end else if (lap_ev) begin
                    state_d   = IDLE;
                    clr_n_d   = 1'b0;
                    clr_rem_d = CLR_MAX;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d     = (state_d == RUN) || (state_d == LAP);
        lap_valid_d = (state_d == LAP);
        disp_d      = (state_q == LAP) ? lap_q : bus.time_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lap_q       <= '0;
            disp_q      <= '0;
            start_q     <= 1'b0;
            lap_valid_q <= 1'b0;
            clr_n_q     <= 1'b1;
            clr_rem_q   <= '0;
        end else begin
            state_q     <= state_d;
            lap_q       <= lap_d;
            disp_q      <= disp_d;
            start_q     <= start_d;
            lap_valid_q <= lap_valid_d;
            clr_n_q     <= clr_n_d;
            clr_rem_q   <= clr_rem_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.timer_start = start_q;
    assign bus.timer_clr_n = clr_n_q;
    assign bus.disp_digits = disp_q;
    assign bus.lap_valid   = lap_valid_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-sample debounce: every expected value below
// is hand-derived (key stable low -> state change 7 clocks later).
module tb_stopwatch_ctrl;

    logic clk;
    logic rst;
    logic key_run;
    logic key_lap;
    int   n_checks = 0;
    int   n_errors = 0;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .DB_CYCLES  (4),
        .CLR_CYCLES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_run (key_run),
        .key_lap (key_lap),
        .bus     (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b0;
        key_run       = 1'b1;
        key_lap       = 1'b1;
        sw_if.time_in = 24'h000000;

        // Reset values
        repeat (3) tick();
        check("rst_state", 24'(sw_if.state), 24'd0);
        check("rst_start", 24'(sw_if.timer_start), 24'd0);
        check("rst_clr_n", 24'(sw_if.timer_clr_n), 24'd1);
        check("rst_lap_valid", 24'(sw_if.lap_valid), 24'd0);
        check("rst_disp", sw_if.disp_digits, 24'h000000);
        rst = 1'b1;
        repeat (5) tick();
        check("idle_after_rst", 24'(sw_if.state), 24'd0);

        // Glitches of 1..3 clocks must be ignored
        for (int w = 1; w <= 3; w++) begin
            key_run = 1'b0;
            repeat (w) tick();
            key_run = 1'b1;
            repeat (8) tick();
            check($sformatf("glitch_%0d", w), 24'(sw_if.state), 24'd0);
        end

        // Held key: RUN exactly 7 clocks after going low
        key_run = 1'b0;
        repeat (6) tick();
        check("run_lat_early", 24'(sw_if.state), 24'd0);
        tick();
        check("run_lat_state", 24'(sw_if.state), 24'd1);
        check("run_lat_start", 24'(sw_if.timer_start), 24'd1);
        repeat (50) tick();
        check("run_hold", 24'(sw_if.state), 24'd1);
        key_run = 1'b1;
        repeat (10) tick();
        check("run_release", 24'(sw_if.state), 24'd1);

        // Lap capture
        sw_if.time_in = 24'h000512;
        tick();
        key_lap = 1'b0;
        repeat (7) tick();
        check("lap_state", 24'(sw_if.state), 24'd3);
        check("lap_valid", 24'(sw_if.lap_valid), 24'd1);
        check("lap_disp", sw_if.disp_digits, 24'h000512);
        key_lap = 1'b1;
        sw_if.time_in = 24'h000520;
        repeat (4) tick();
        sw_if.time_in = 24'h000529;
        repeat (4) tick();
        sw_if.time_in = 24'h000530;
        repeat (4) tick();
        check("lap_frozen_disp", sw_if.disp_digits, 24'h000512);
        check("lap_start", 24'(sw_if.timer_start), 24'd1);
        check("lap_still", 24'(sw_if.state), 24'd3);
        key_lap = 1'b0;
        repeat (7) tick();
        check("lap_exit_state", 24'(sw_if.state), 24'd1);
        check("lap_exit_valid", 24'(sw_if.lap_valid), 24'd0);
        tick();
        check("lap_exit_disp", sw_if.disp_digits, 24'h000530);
        key_lap = 1'b1;
        repeat (10) tick();

        // Pause, then clear back to IDLE
        key_run = 1'b0;
        repeat (7) tick();
        check("pause_state", 24'(sw_if.state), 24'd2);
        check("pause_start", 24'(sw_if.timer_start), 24'd0);
        key_run = 1'b1;
        repeat (10) tick();
        key_lap = 1'b0;
        repeat (7) tick();
        check("clr_state", 24'(sw_if.state), 24'd0);
        check("clr_pulse_1", 24'(sw_if.timer_clr_n), 24'd0);
        tick();
        check("clr_pulse_2", 24'(sw_if.timer_clr_n), 24'd0);
        tick();
        check("clr_pulse_end", 24'(sw_if.timer_clr_n), 24'd1);
        key_lap = 1'b1;
        repeat (10) tick();
        key_lap = 1'b0;
        repeat (10) tick();
        check("idle_lap_state", 24'(sw_if.state), 24'd0);
        check("idle_lap_clr_n", 24'(sw_if.timer_clr_n), 24'd1);
        check("idle_lap_start", 24'(sw_if.timer_start), 24'd0);
        key_lap = 1'b1;
        repeat (10) tick();

        // Simultaneous presses in RUN: run wins
        key_run = 1'b0;
        repeat (7) tick();
        check("sim_pre_run", 24'(sw_if.state), 24'd1);
        key_run = 1'b1;
        repeat (10) tick();
        sw_if.time_in = 24'h000777;
        key_run = 1'b0;
        key_lap = 1'b0;
        repeat (7) tick();
        check("sim_state", 24'(sw_if.state), 24'd2);
        check("sim_lap_valid", 24'(sw_if.lap_valid), 24'd0);
        check("sim_clr_n", 24'(sw_if.timer_clr_n), 24'd1);
        tick();
        check("sim_clr_n_after", 24'(sw_if.timer_clr_n), 24'd1);
        check("sim_disp_live", sw_if.disp_digits, 24'h000777);
        key_run = 1'b1;
        key_lap = 1'b1;
        repeat (10) tick();

        // Reset asserted in LAP, mid-cycle, with keys held through deassertion
        key_run = 1'b0;
        repeat (7) tick();
        check("r6_run", 24'(sw_if.state), 24'd1);
        key_run = 1'b1;
        repeat (10) tick();
        sw_if.time_in = 24'h001000;
        key_lap = 1'b0;
        repeat (7) tick();
        check("r6_lap", 24'(sw_if.state), 24'd3);
        #3 rst = 1'b0;
        #1;
        check("r6_async_state", 24'(sw_if.state), 24'd0);
        check("r6_async_valid", 24'(sw_if.lap_valid), 24'd0);
        check("r6_async_start", 24'(sw_if.timer_start), 24'd0);
        check("r6_async_disp", sw_if.disp_digits, 24'h000000);
        check("r6_async_clr_n", 24'(sw_if.timer_clr_n), 24'd1);
        key_run = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (20) tick();
        check("r6_held_state", 24'(sw_if.state), 24'd0);
        check("r6_held_start", 24'(sw_if.timer_start), 24'd0);
        key_run = 1'b1;
        key_lap = 1'b1;
        repeat (10) tick();
        key_run = 1'b0;
        repeat (7) tick();
        check("r6_repress_run", 24'(sw_if.state), 24'd1);
        key_run = 1'b1;
        repeat (10) tick();
        sw_if.time_in = 24'h002345;
        key_lap = 1'b0;
        repeat (7) tick();
        check("r6_repress_lap", 24'(sw_if.state), 24'd3);
        check("r6_repress_disp", sw_if.disp_digits, 24'h002345);
        key_lap = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
